dbus_ctrl: RTL and testbench

- Sits directly downstream of the load/store unit, on its data-bus side.
- Accepts the LSU request: address, load/store request, store size and write data.
- Runs a registered, single-outstanding bus cycle to data memory, with byte strobes, a misalignment check and a response timeout.
- Returns a one-cycle ack with read data to the LSU, and discards responses of flushed requests.

---
 rtl/dbus_ctrl.sv | 153 +++++++++++++++
 tb/tb_dbus_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dbus_ctrl.sv
`default_nettype none
// ============================================================================
// dbus_ctrl : single-outstanding LSU-to-data-memory bus controller  (rev 1.0)
// ============================================================================
module dbus_ctrl #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int TO_W           = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] lsu_addr_i,
   input  logic        lsu_ld_req_i,
   input  logic        lsu_st_req_i,
   input  logic [1:0]  lsu_st_ops_i,
   input  logic [31:0] lsu_w_data_i,
   input  logic        lsu_flush_i,
   output logic        lsu_ack_o,
   output logic [31:0] lsu_r_data_o,
   output logic        lsu_err_o,
   output logic        mem_cyc_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_sel_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_w_data_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_r_data_i
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      ERR   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t          state, state_nx;
   logic [TO_W-1:0] cnt, cnt_nx;
   logic            is_load;
   logic            req, is_store, aligned, launch, timeout;
   logic [3:0]      sel_nx;
   logic [31:0]     wdata_nx;

   // Request decode; a simultaneous load+store is treated as a store.
   always_comb begin
      req      = lsu_ld_req_i | lsu_st_req_i;
      is_store = lsu_st_req_i;
      aligned  = 1'b1;
      sel_nx   = 4'b1111;
      wdata_nx = lsu_w_data_i;
      if (is_store) begin
         case (lsu_st_ops_i)
            2'd1: begin
               sel_nx   = 4'b0001 << lsu_addr_i[1:0];
               wdata_nx = {4{lsu_w_data_i[7:0]}};
            end
            2'd2: begin
               aligned  = ~lsu_addr_i[0];
               sel_nx   = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
               wdata_nx = {2{lsu_w_data_i[15:0]}};
            end
            default: aligned = (lsu_addr_i[1:0] == 2'b00);
         endcase
      end
   end

   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      launch       = 1'b0;
      lsu_ack_o    = 1'b0;
      lsu_err_o    = 1'b0;
      lsu_r_data_o = 32'd0;
      timeout      = (cnt == TO_LAST);
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (req && !lsu_flush_i) begin
               if (aligned) begin
                  launch   = 1'b1;
                  state_nx = REQ;
               end else begin
                  state_nx = ERR;
               end
            end
         end
         REQ: begin
            if (mem_ack_i) begin
               state_nx = IDLE;
               if (!lsu_flush_i) begin
                  lsu_ack_o    = 1'b1;
                  lsu_r_data_o = is_load ? mem_r_data_i : 32'd0;
               end
            end else if (timeout) begin
               state_nx = IDLE;
               if (!lsu_flush_i) begin
                  lsu_ack_o = 1'b1;
                  lsu_err_o = 1'b1;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
               if (lsu_flush_i) state_nx = DRAIN;
            end
         end
         DRAIN: begin
            // The flushed cycle must still complete on the bus before reuse.
            if (mem_ack_i || timeout) state_nx = IDLE;
            else                      cnt_nx   = cnt + 1'b1;
         end
         ERR: begin
            state_nx = IDLE;
            if (!lsu_flush_i) begin
               lsu_ack_o = 1'b1;
               lsu_err_o = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         is_load      <= 1'b0;
         mem_cyc_o    <= 1'b0;
         mem_we_o     <= 1'b0;
         mem_sel_o    <= 4'd0;
         mem_addr_o   <= 32'd0;
         mem_w_data_o <= 32'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (launch) begin
            is_load      <= ~is_store;
            mem_cyc_o    <= 1'b1;
            mem_we_o     <= is_store;
            mem_sel_o    <= sel_nx;
            mem_addr_o   <= {lsu_addr_i[31:2], 2'b00};
            mem_w_data_o <= is_store ? wdata_nx : 32'd0;
         end else if (state_nx == IDLE) begin
            mem_cyc_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_sel_o    <= 4'd0;
            mem_addr_o   <= 32'd0;
            mem_w_data_o <= 32'd0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dbus_ctrl.sv
`default_nettype none
// ============================================================================
// tb_dbus_ctrl : directed self-checking bench for dbus_ctrl  (rev 1.0)
// ============================================================================
module tb_dbus_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] lsu_addr_i;
   logic        lsu_ld_req_i, lsu_st_req_i;
   logic [1:0]  lsu_st_ops_i;
   logic [31:0] lsu_w_data_i;
   logic        lsu_flush_i;
   logic        lsu_ack_o, lsu_err_o;
   logic [31:0] lsu_r_data_o;
   logic        mem_cyc_o, mem_we_o;
   logic [3:0]  mem_sel_o;
   logic [31:0] mem_addr_o, mem_w_data_o;
   logic        mem_ack_i;
   logic [31:0] mem_r_data_i;

   int checks   = 0;
   int failures = 0;

   dbus_ctrl #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .lsu_addr_i(lsu_addr_i), .lsu_ld_req_i(lsu_ld_req_i), .lsu_st_req_i(lsu_st_req_i),
      .lsu_st_ops_i(lsu_st_ops_i), .lsu_w_data_i(lsu_w_data_i), .lsu_flush_i(lsu_flush_i),
      .lsu_ack_o(lsu_ack_o), .lsu_r_data_o(lsu_r_data_o), .lsu_err_o(lsu_err_o),
      .mem_cyc_o(mem_cyc_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o),
      .mem_addr_o(mem_addr_o), .mem_w_data_o(mem_w_data_o),
      .mem_ack_i(mem_ack_i), .mem_r_data_i(mem_r_data_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after driving inputs.
   task automatic settle();
      #1;
   endtask

   task automatic drive(input logic ld, input logic st, input logic [1:0] ops,
                        input logic [31:0] addr, input logic [31:0] w);
      lsu_ld_req_i = ld;
      lsu_st_req_i = st;
      lsu_st_ops_i = ops;
      lsu_addr_i   = addr;
      lsu_w_data_i = w;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
      lsu_flush_i  = 1'b0;
      mem_ack_i    = 1'b0;
      mem_r_data_i = 32'd0;
      tick(); tick();
      rst_n = 1'b1;
      settle();
      chk("rst_cyc", {31'd0, mem_cyc_o}, 32'd0);
      chk("rst_sel", {28'd0, mem_sel_o}, 32'd0);
      chk("rst_ack", {31'd0, lsu_ack_o}, 32'd0);

      // LW 0x1000, memory answers in the first REQ cycle
      tick(); drive(1'b1, 1'b0, 2'd0, 32'h1000, 32'd0); settle();
      chk("lw_idle_ack", {31'd0, lsu_ack_o}, 32'd0);
      tick(); mem_ack_i = 1'b1; mem_r_data_i = 32'hDEADBEEF; settle();
      chk("lw_cyc",   {31'd0, mem_cyc_o}, 32'd1);
      chk("lw_addr",  mem_addr_o, 32'h1000);
      chk("lw_sel",   {28'd0, mem_sel_o}, 32'hF);
      chk("lw_we",    {31'd0, mem_we_o}, 32'd0);
      chk("lw_ack",   {31'd0, lsu_ack_o}, 32'd1);
      chk("lw_err",   {31'd0, lsu_err_o}, 32'd0);
      chk("lw_rdata", lsu_r_data_o, 32'hDEADBEEF);
      tick(); drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0); mem_ack_i = 1'b0; settle();
      chk("lw_cyc_drop", {31'd0, mem_cyc_o}, 32'd0);
      chk("lw_ack_once", {31'd0, lsu_ack_o}, 32'd0);

      // SB 0x1003, one wait cycle before memory ack
      tick(); drive(1'b0, 1'b1, 2'd1, 32'h1003, 32'h000000A5); settle();
      tick(); settle();
      chk("sb_sel",   {28'd0, mem_sel_o}, 32'h8);
      chk("sb_wdata", mem_w_data_o, 32'hA5A5A5A5);
      chk("sb_we",    {31'd0, mem_we_o}, 32'd1);
      chk("sb_addr",  mem_addr_o, 32'h1000);
      chk("sb_wait",  {31'd0, lsu_ack_o}, 32'd0);
      tick(); mem_ack_i = 1'b1; mem_r_data_i = 32'h11111111; settle();
      chk("sb_ack",   {31'd0, lsu_ack_o}, 32'd1);
      chk("sb_rdata", lsu_r_data_o, 32'd0);
      tick(); drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0); mem_ack_i = 1'b0; settle();
      chk("sb_cyc_drop", {31'd0, mem_cyc_o}, 32'd0);

      // SH 0x1002
      tick(); drive(1'b0, 1'b1, 2'd2, 32'h1002, 32'h00001234); settle();
      tick(); mem_ack_i = 1'b1; settle();
      chk("sh_sel",   {28'd0, mem_sel_o}, 32'hC);
      chk("sh_wdata", mem_w_data_o, 32'h12341234);
      chk("sh_ack",   {31'd0, lsu_ack_o}, 32'd1);
      tick(); drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0); mem_ack_i = 1'b0; settle();

      // Misaligned SW 0x1002 and SH 0x1001: error ack, no bus cycle
      for (int m = 0; m < 2; m++) begin
         tick();
         if (m == 0) drive(1'b0, 1'b1, 2'd3, 32'h1002, 32'h0);
         else        drive(1'b0, 1'b1, 2'd2, 32'h1001, 32'h0);
         settle();
         tick(); settle();
         chk("mis_cyc", {31'd0, mem_cyc_o}, 32'd0);
         chk("mis_ack", {31'd0, lsu_ack_o}, 32'd1);
         chk("mis_err", {31'd0, lsu_err_o}, 32'd1);
         tick(); drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0); settle();
         chk("mis_cyc2", {31'd0, mem_cyc_o}, 32'd0);
         chk("mis_ack2", {31'd0, lsu_ack_o}, 32'd0);
      end

      // Timeout: ack+err in the 16th REQ cycle
      mem_r_data_i = 32'hFFFFFFFF;
      tick(); drive(1'b1, 1'b0, 2'd0, 32'h2000, 32'd0); settle();
      for (int k = 1; k <= 16; k++) begin
         tick(); settle();
         chk("to_cyc", {31'd0, mem_cyc_o}, 32'd1);
         chk("to_ack", {31'd0, lsu_ack_o}, (k == 16) ? 32'd1 : 32'd0);
      end
      chk("to_err",   {31'd0, lsu_err_o}, 32'd1);
      chk("to_rdata", lsu_r_data_o, 32'd0);
      tick(); drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0); settle();
      chk("to_cyc_drop", {31'd0, mem_cyc_o}, 32'd0);

      // Flush in REQ cycle 2, memory ack in cycle 5, next load waits for DRAIN
      tick(); drive(1'b1, 1'b0, 2'd0, 32'h3000, 32'd0); settle();
      tick(); settle();                                    // REQ cycle 1
      tick(); lsu_flush_i = 1'b1; settle();                // cycle 2
      chk("fl_ack_c2", {31'd0, lsu_ack_o}, 32'd0);
      tick(); lsu_flush_i = 1'b0;
      drive(1'b1, 1'b0, 2'd0, 32'h3004, 32'd0); settle();  // cycle 3
      chk("fl_cyc_c3", {31'd0, mem_cyc_o}, 32'd1);
      chk("fl_addr_c3", mem_addr_o, 32'h3000);
      tick(); settle();                                    // cycle 4
      chk("fl_ack_c4", {31'd0, lsu_ack_o}, 32'd0);
      tick(); mem_ack_i = 1'b1; mem_r_data_i = 32'h0BADF00D; settle(); // cycle 5
      chk("fl_cyc_c5", {31'd0, mem_cyc_o}, 32'd1);
      chk("fl_ack_c5", {31'd0, lsu_ack_o}, 32'd0);
      tick(); mem_ack_i = 1'b0; settle();                  // cycle 6: IDLE
      chk("fl_cyc_c6", {31'd0, mem_cyc_o}, 32'd0);
      chk("fl_ack_c6", {31'd0, lsu_ack_o}, 32'd0);
      tick(); mem_ack_i = 1'b1; mem_r_data_i = 32'hCAFEF00D; settle(); // cycle 7
      chk("fl_new_addr", mem_addr_o, 32'h3004);
      chk("fl_new_ack",  {31'd0, lsu_ack_o}, 32'd1);
      chk("fl_new_data", lsu_r_data_o, 32'hCAFEF00D);
      tick(); drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0); mem_ack_i = 1'b0; settle();

      // Reset in REQ, memory ack arrives afterwards
      tick(); drive(1'b1, 1'b0, 2'd0, 32'h4000, 32'd0); settle();
      tick(); settle();
      chk("rr_cyc_pre", {31'd0, mem_cyc_o}, 32'd1);
      rst_n = 1'b0; drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
      tick(); rst_n = 1'b1; mem_ack_i = 1'b1; mem_r_data_i = 32'h55AA55AA; settle();
      chk("rr_cyc",  {31'd0, mem_cyc_o}, 32'd0);
      chk("rr_we",   {31'd0, mem_we_o}, 32'd0);
      chk("rr_sel",  {28'd0, mem_sel_o}, 32'd0);
      chk("rr_addr", mem_addr_o, 32'd0);
      chk("rr_wdat", mem_w_data_o, 32'd0);
      chk("rr_ack",  {31'd0, lsu_ack_o}, 32'd0);
      chk("rr_rdat", lsu_r_data_o, 32'd0);
      tick(); mem_ack_i = 1'b0; settle();
      chk("rr_idle", {31'd0, mem_cyc_o}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
